// File: rtl/cadss_bus_arbiter.sv
// Snooping bus core: round-robin arbitration over N caches, one-cycle snoop
// broadcast, latency countdown, then a one-cycle response to the requester.
module cadss_bus_arbiter #(
  parameter int unsigned NUM_PROCS   = 4,
  parameter int unsigned ADDR_W      = 64,
  parameter int unsigned MEM_LATENCY = 10,
  parameter int unsigned C2C_LATENCY = 3,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                          clk,
  input  logic                          rst_l,
  input  logic [NUM_PROCS-1:0]          req_valid,
  input  logic [2*NUM_PROCS-1:0]        req_op,
  input  logic [ADDR_W*NUM_PROCS-1:0]   req_addr,
  output logic [NUM_PROCS-1:0]          req_ready,
  output logic                          snoop_valid,
  output logic [1:0]                    snoop_op,
  output logic [ADDR_W-1:0]             snoop_addr,
  output logic [$clog2(NUM_PROCS)-1:0]  snoop_src,
  input  logic [NUM_PROCS-1:0]          snoop_shared_in,
  input  logic [NUM_PROCS-1:0]          snoop_supply_in,
  output logic [NUM_PROCS-1:0]          resp_valid,
  output logic                          resp_shared,
  output logic                          busy,
  output logic [CNT_W-1:0]              txn_count
);

  localparam int unsigned SRC_W   = $clog2(NUM_PROCS);
  localparam int unsigned MAX_LAT = (MEM_LATENCY > C2C_LATENCY) ? MEM_LATENCY : C2C_LATENCY;
  localparam int unsigned LAT_W   = $clog2(MAX_LAT + 1);
  localparam logic [1:0]  OP_UPGR = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_SNOOP, S_WAIT, S_RESP} state_t;

  state_t                state, state_nxt;
  logic [SRC_W-1:0]      rr_ptr;
  logic [SRC_W-1:0]      src_q;
  logic [1:0]            op_q;
  logic [ADDR_W-1:0]     addr_q;
  logic                  shared_acc;
  logic [LAT_W-1:0]      cnt;
  logic                  win_found;
  logic [SRC_W-1:0]      win_idx;
  logic [1:0]            win_op;
  logic [ADDR_W-1:0]     win_addr;
  logic                  hs;
  logic [NUM_PROCS-1:0]  own_mask;
  logic [NUM_PROCS-1:0]  shared_masked;
  logic [NUM_PROCS-1:0]  supply_masked;

  // Round-robin winner: first valid requester at or above rr_ptr, with wrap.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned i = 0; i < NUM_PROCS; i++) begin
      logic [SRC_W:0] sum;
      sum = {1'b0, rr_ptr} + (SRC_W+1)'(i);
      if (sum >= (SRC_W+1)'(NUM_PROCS)) sum = sum - (SRC_W+1)'(NUM_PROCS);
      if (!win_found && req_valid[sum[SRC_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = sum[SRC_W-1:0];
      end
    end
  end

  // Select the winner's op and address.
  always_comb begin
    win_op   = '0;
    win_addr = '0;
    for (int unsigned i = 0; i < NUM_PROCS; i++) begin
      if (SRC_W'(i) == win_idx) begin
        win_op   = req_op[2*i +: 2];
        win_addr = req_addr[ADDR_W*i +: ADDR_W];
      end
    end
  end

  // Snoop responses with the requester's own bit removed.
  always_comb begin
    own_mask         = '0;
    own_mask[src_q]  = 1'b1;
    shared_masked    = snoop_shared_in & ~own_mask;
    supply_masked    = snoop_supply_in & ~own_mask;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and grant logic.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    hs        = 1'b0;
    case (state)
      S_IDLE: begin
        if (win_found) begin
          req_ready[win_idx] = 1'b1;
          hs                 = 1'b1;
          state_nxt          = S_SNOOP;
        end
      end
      S_SNOOP: state_nxt = (op_q == OP_UPGR) ? S_RESP : S_WAIT;
      S_WAIT:  if (cnt == '0) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Transaction datapath: capture on grant, latch snoop result, count down, count completions.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rr_ptr     <= '0;
      src_q      <= '0;
      op_q       <= '0;
      addr_q     <= '0;
      shared_acc <= 1'b0;
      cnt        <= '0;
      txn_count  <= '0;
    end else begin
      if (hs) begin
        src_q  <= win_idx;
        op_q   <= win_op;
        addr_q <= win_addr;
        rr_ptr <= (win_idx == SRC_W'(NUM_PROCS - 1)) ? '0 : win_idx + SRC_W'(1);
      end
      if (state == S_SNOOP) begin
        shared_acc <= |shared_masked;
        cnt        <= (|supply_masked) ? LAT_W'(C2C_LATENCY - 1) : LAT_W'(MEM_LATENCY - 1);
      end
      if (state == S_WAIT && cnt != '0) cnt <= cnt - LAT_W'(1);
      if (state == S_RESP) txn_count <= txn_count + CNT_W'(1);
    end
  end

  // Output decode from registered state.
  always_comb begin
    snoop_valid       = (state == S_SNOOP);
    snoop_op          = op_q;
    snoop_addr        = addr_q;
    snoop_src         = src_q;
    resp_valid        = '0;
    if (state == S_RESP) resp_valid[src_q] = 1'b1;
    resp_shared       = (state == S_RESP) & shared_acc;
    busy              = (state != S_IDLE);
  end

endmodule

// File: doc/cadss_bus_arbiter.md
Name: cadss_bus_arbiter

Overview:
- Synthesizable snooping-bus core for the cache-network simulator. Replaces the fixed single-bus tick shell with a parametrised N-requester bus.
- Arbitrates cache miss/upgrade requests round-robin and broadcasts each granted transaction to all snoopers.
- Models memory or cache-to-cache latency with a countdown, then returns a one-cycle response to the requester.
- Sits between the per-core cache models and the memory model inside the interconnect top.

Parameters:
NUM_PROCS, 4, number of requesting caches (2..16)
ADDR_W, 64, address width
MEM_LATENCY, 10, cycles spent in WAIT when memory supplies data (>=1)
C2C_LATENCY, 3, cycles spent in WAIT when a peer cache supplies data (>=1)
CNT_W, 32, transaction counter width

Ports:
clk  in  1  clock
rst_l  in  1  asynchronous active-low reset
req_valid  in  NUM_PROCS  per-cache request valid
req_op  in  2*NUM_PROCS  per-cache op: 0=BusRd, 1=BusRdX, 2=BusUpgr, 3=reserved (treated as BusRd)
req_addr  in  ADDR_W*NUM_PROCS  per-cache request address
req_ready  out  NUM_PROCS  grant/accept, one-hot or zero
snoop_valid  out  1  broadcast strobe
snoop_op  out  2  broadcast op
snoop_addr  out  ADDR_W  broadcast address
snoop_src  out  $clog2(NUM_PROCS)  requester index
snoop_shared_in  in  NUM_PROCS  per-cache "I hold the line", sampled in SNOOP cycle
snoop_supply_in  in  NUM_PROCS  per-cache "I supply data", sampled in SNOOP cycle
resp_valid  out  NUM_PROCS  one-hot completion pulse to requester
resp_shared  out  1  OR of non-requester shared bits, valid with resp_valid
busy  out  1  state != IDLE
txn_count  out  CNT_W  completed transactions, wraps

Behaviour:
- Reset (async assert, sync-safe release):
  - State is IDLE, rr_ptr=0 and txn_count=0.
  - All outputs are 0. Any in-flight transaction is dropped with no resp_valid.
- States: IDLE -> SNOOP -> WAIT -> RESP -> IDLE. BusUpgr goes SNOOP -> RESP and skips WAIT.
- IDLE:
  - If any req_valid is set, the winner is the first set bit scanning from rr_ptr upward with wrap.
  - req_ready[winner]=1 combinationally in that cycle; the handshake is valid&ready.
  - On the handshake, register op, addr and src, set rr_ptr=(winner+1) mod NUM_PROCS, and go to SNOOP.
  - If no request is valid, stay in IDLE and leave rr_ptr unchanged.
- req_ready is 0 in every state other than IDLE.
- Requesters must hold valid, op and addr stable until the handshake. A dropped valid before the handshake is legal and is simply not granted.
- SNOOP (exactly 1 cycle):
  - snoop_valid=1 with the registered op, addr and src.
  - Sample shared/supply with the requester's own bit masked to 0, and latch shared_acc = OR(masked shared).
  - Next state:
    - BusUpgr: RESP.
    - Else if any masked supply bit is set: WAIT with counter=C2C_LATENCY-1.
    - Else: WAIT with counter=MEM_LATENCY-1.
- WAIT: decrement each cycle. When the counter is 0, go to RESP; WAIT therefore lasts exactly L cycles.
- RESP (1 cycle):
  - resp_valid[src]=1 and resp_shared=shared_acc.
  - txn_count increments modulo 2^CNT_W. Next state is IDLE.
- Latency from the handshake cycle t:
  - snoop_valid at t+1.
  - resp_valid at t+2+L for reads, t+2 for BusUpgr.
  - The earliest next handshake is t+3+L (t+3 for BusUpgr).
- snoop_op, snoop_addr and snoop_src hold their last values outside SNOOP. Only snoop_valid qualifies them.
- A request arriving while busy waits; there is no queueing inside this block.
- When the requester asserts req_valid again during RESP, it is eligible in the following IDLE cycle under rr_ptr.

Test Plan:
- Single BusRd from cache 1, addr 0x1000, no sharers, MEM_LATENCY=10, handshake at cycle 0 -> snoop_valid at cycle 1 (src=1, addr 0x1000), resp_valid=4'b0010 at cycle 12, resp_shared=0, txn_count=1.
- All four req_valid held high from reset -> grants in order 0,1,2,3,0 with handshakes spaced 13 cycles apart; req_ready is always one-hot.
- rr_ptr=3 after grant to 2, caches 0 and 3 valid -> cache 3 granted first, then cache 0.
- BusUpgr from cache 2 with snoop_shared_in=4'b0101 -> resp_valid at t+2, resp_shared=1; with shared_in=4'b0100 (own bit only) -> resp_shared=0.
- BusRd from cache 0 with snoop_supply_in=4'b1000 -> resp at t+5 (C2C_LATENCY=3); with supply_in=4'b0001 (own bit) -> resp at t+12.
- rst_l asserted at the 5th cycle of WAIT -> outputs 0 immediately, busy=0, no resp_valid; after release, a fresh request from cache 0 is granted with rr_ptr=0.
